// File: rtl/vga_mode_sel_pkg.sv
// Shared definitions for the VGA display-mode selector: named mode indices
// for the pattern/colour mux, 50 MHz timing defaults and the step direction type.
package vga_mode_sel_pkg;

    // Mode indices consumed by the pattern/colour mux in the VGA top level.
    localparam int VGA_MODE_BARS    = 0;
    localparam int VGA_MODE_GRID    = 1;
    localparam int VGA_MODE_CHECKER = 2;
    localparam int VGA_MODE_GRAD_H  = 3;
    localparam int VGA_MODE_GRAD_V  = 4;
    localparam int VGA_MODE_RED     = 5;
    localparam int VGA_MODE_GREEN   = 6;
    localparam int VGA_MODE_BLUE    = 7;
    localparam int VGA_MODE_WHITE   = 8;
    localparam int VGA_MODE_BORDER  = 9;
    localparam int VGA_MODE_CROSS   = 10;

    // Timing defaults for a 50 MHz system clock: 20 ms debounce, 1 s dwell.
    localparam int DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int DEF_AUTO_CYC     = 50_000_000;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2
    } step_e;

endpackage

// File: rtl/vga_mode_sel_key_debounce.sv
// Single-key conditioner: polarity normalise, 2-FF synchroniser, stability
// counter and a registered one-cycle pulse on each accepted press.
module vga_mode_sel_key_debounce #(
    parameter int DEBOUNCE_CYC = 1,
    parameter int KEY_ACT_LOW  = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_raw_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             key_norm;
    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Internally 1 always means pressed, whatever the board wiring.
    assign key_norm = (KEY_ACT_LOW != 0) ? ~key_raw_i : key_raw_i;

    // Count consecutive mismatching cycles; accept the new level on the last one.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state; reset forgets all history (level = released).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_norm;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/vga_mode_sel.sv
// Display-mode selector: two debounced keys step the mode index up/down with
// wrap or saturate, an optional dwell timer auto-advances, and every change
// is flagged by a registered one-cycle pulse.
module vga_mode_sel
    import vga_mode_sel_pkg::*;
#(
    parameter int NUM_MODES    = 11,
    parameter int MODE_W       = 4,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int AUTO_CYC     = DEF_AUTO_CYC,
    parameter int WRAP         = 1,
    parameter int KEY_ACT_LOW  = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              key_next,
    input  logic              key_prev,
    input  logic              auto_en,
    output logic [MODE_W-1:0] mode,
    output logic              mode_chg,
    output logic              mode_wrap
);

    localparam int DWELL_W = (AUTO_CYC > 2) ? $clog2(AUTO_CYC) : 1;
    localparam logic [MODE_W-1:0]  MODE_MAX   = MODE_W'(NUM_MODES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(AUTO_CYC - 1);

    generate
        if (NUM_MODES < 2) begin : g_err_num_modes
            $error("vga_mode_sel: NUM_MODES must be >= 2");
        end
        if (DEBOUNCE_CYC < 1) begin : g_err_debounce
            $error("vga_mode_sel: DEBOUNCE_CYC must be >= 1");
        end
        if ((2 ** MODE_W) < NUM_MODES) begin : g_err_mode_w
            $error("vga_mode_sel: MODE_W too narrow for NUM_MODES");
        end
        if (AUTO_CYC < 2) begin : g_err_auto
            $error("vga_mode_sel: AUTO_CYC must be >= 2");
        end
    endgenerate

    logic               press_next, press_prev;
    logic               key_step, tick;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    step_e              step_dir;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic               chg_q, chg_d;
    logic               wrap_q, wrap_d;

    vga_mode_sel_key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .KEY_ACT_LOW  (KEY_ACT_LOW)
    ) u_deb_next (
        .clk_i     (sys_clk),
        .rst_i     (sys_rst),
        .key_raw_i (key_next),
        .press_o   (press_next)
    );

    vga_mode_sel_key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .KEY_ACT_LOW  (KEY_ACT_LOW)
    ) u_deb_prev (
        .clk_i     (sys_clk),
        .rst_i     (sys_rst),
        .key_raw_i (key_prev),
        .press_o   (press_prev)
    );

    // One step of the mode index, wrapping or saturating at both ends.
    // Returns {changed, wrapped, new_mode}.
    function automatic logic [MODE_W+1:0] step_mode(input logic [MODE_W-1:0] cur,
                                                    input step_e dir);
        logic [MODE_W-1:0] nxt;
        logic              chg;
        logic              wrp;
        nxt = cur;
        chg = 1'b0;
        wrp = 1'b0;
        case (dir)
            STEP_UP: begin
                if (cur >= MODE_MAX) begin
                    if (WRAP != 0) begin
                        nxt = '0;
                        chg = 1'b1;
                        wrp = 1'b1;
                    end
                end else begin
                    nxt = cur + 1'b1;
                    chg = 1'b1;
                end
            end
            STEP_DN: begin
                if (cur == '0) begin
                    if (WRAP != 0) begin
                        nxt = MODE_MAX;
                        chg = 1'b1;
                        wrp = 1'b1;
                    end
                end else begin
                    nxt = cur - 1'b1;
                    chg = 1'b1;
                end
            end
            default: ;
        endcase
        return {chg, wrp, nxt};
    endfunction

    // A lone key press is a step; both keys together cancel out.
    assign key_step = press_next ^ press_prev;
    assign tick     = auto_en && (dwell_q == DWELL_LAST);

    // Dwell counter: runs only while enabled, restarts on a tick or a key step.
    always_comb begin
        dwell_d = dwell_q + 1'b1;
        if (!auto_en || tick || key_step) begin
            dwell_d = '0;
        end
    end

    // Dwell register; reset discards any partial dwell.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end

    // Next-state: keys beat the auto tick, simultaneous presses are ignored.
    always_comb begin
        step_dir = STEP_NONE;
        if (press_next && press_prev) begin
            step_dir = STEP_NONE;
        end else if (press_next) begin
            step_dir = STEP_UP;
        end else if (press_prev) begin
            step_dir = STEP_DN;
        end else if (tick) begin
            step_dir = STEP_UP;
        end
        {chg_d, wrap_d, mode_d} = step_mode(mode_q, step_dir);
    end

    // Mode and change flags are registered so the pulses align with the new mode.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q <= '0;
            chg_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            chg_q  <= chg_d;
            wrap_q <= wrap_d;
        end
    end

    // Outputs straight from the registers.
    always_comb begin
        mode      = mode_q;
        mode_chg  = chg_q;
        mode_wrap = wrap_q;
    end

endmodule

// File: tb/tb_vga_mode_sel.sv
// Bench for vga_mode_sel: one wrapping active-high instance and one saturating
// active-low instance; expected mode changes are queued as stimulus is applied
// and matched against each mode_chg pulse.
module tb_vga_mode_sel;

    localparam int NM = 5;
    localparam int MW = 3;
    localparam int DB = 4;
    localparam int AC = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Wrapping instance, active-high keys.
    logic          rst, kn, kp, ae;
    logic [MW-1:0] mode_w;
    logic          chg_w, wrap_w;
    // Saturating instance, active-low keys.
    logic          rst2, kn2, kp2, ae2;
    logic [MW-1:0] mode_s;
    logic          chg_s, wrap_s;

    int passed = 0;
    int total  = 0;
    logic [3:0] q_w[$];
    logic [3:0] q_s[$];
    int exp_w = 0;
    int exp_s = 0;

    vga_mode_sel #(
        .NUM_MODES(NM), .MODE_W(MW), .DEBOUNCE_CYC(DB), .AUTO_CYC(AC),
        .WRAP(1), .KEY_ACT_LOW(0)
    ) dut_w (
        .sys_clk(clk), .sys_rst(rst), .key_next(kn), .key_prev(kp), .auto_en(ae),
        .mode(mode_w), .mode_chg(chg_w), .mode_wrap(wrap_w)
    );

    vga_mode_sel #(
        .NUM_MODES(NM), .MODE_W(MW), .DEBOUNCE_CYC(DB), .AUTO_CYC(AC),
        .WRAP(0), .KEY_ACT_LOW(1)
    ) dut_s (
        .sys_clk(clk), .sys_rst(rst2), .key_next(kn2), .key_prev(kp2), .auto_en(ae2),
        .mode(mode_s), .mode_chg(chg_s), .mode_wrap(wrap_s)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int which, input logic lvl);
        case (which)
            0: kn  = lvl;
            1: kp  = lvl;
            2: kn2 = ~lvl;
            default: kp2 = ~lvl;
        endcase
    endtask

    task automatic press_key(input int which);
        drive(which, 1'b1);
        step(10);
        drive(which, 1'b0);
        step(10);
    endtask

    task automatic push_next_w();
        if (exp_w == NM - 1) begin
            exp_w = 0;
            q_w.push_back(4'b1000);
        end else begin
            exp_w = exp_w + 1;
            q_w.push_back({1'b0, 3'(exp_w)});
        end
    endtask

    task automatic push_prev_w();
        if (exp_w == 0) begin
            exp_w = NM - 1;
            q_w.push_back({1'b1, 3'(NM - 1)});
        end else begin
            exp_w = exp_w - 1;
            q_w.push_back({1'b0, 3'(exp_w)});
        end
    endtask

    task automatic reset_w();
        rst = 1'b1;
        kn  = 1'b0;
        kp  = 1'b0;
        ae  = 1'b0;
        step(2);
        rst   = 1'b0;
        exp_w = 0;
    endtask

    task automatic mon_w();
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (chg_w === 1'b1) begin
                total++;
                if (q_w.size() == 0) begin
                    $display("FAIL w_change: unexpected mode_chg mode=%0d wrap=%0b, required no change",
                             mode_w, wrap_w);
                end else begin
                    e = q_w.pop_front();
                    if ({wrap_w, mode_w} !== e)
                        $display("FAIL w_change: mode=%0d wrap=%0b, required mode=%0d wrap=%0b",
                                 mode_w, wrap_w, e[2:0], e[3]);
                    else
                        passed++;
                end
            end else if (wrap_w !== 1'b0) begin
                total++;
                $display("FAIL w_wrapflag: mode_wrap=%b without mode_chg, required 0", wrap_w);
            end
        end
    endtask

    task automatic mon_s();
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (chg_s === 1'b1) begin
                total++;
                if (q_s.size() == 0) begin
                    $display("FAIL s_change: unexpected mode_chg mode=%0d wrap=%0b, required no change",
                             mode_s, wrap_s);
                end else begin
                    e = q_s.pop_front();
                    if ({wrap_s, mode_s} !== e)
                        $display("FAIL s_change: mode=%0d wrap=%0b, required mode=%0d wrap=%0b",
                                 mode_s, wrap_s, e[2:0], e[3]);
                    else
                        passed++;
                end
            end else if (wrap_s !== 1'b0) begin
                total++;
                $display("FAIL s_wrapflag: mode_wrap=%b without mode_chg, required 0", wrap_s);
            end
        end
    endtask

    task automatic test_reset();
        kn = 1'b1;
        rst = 1'b1;
        step(4);
        total++;
        if (mode_w !== 3'd0) $display("FAIL reset_mode: mode=%0d, required 0", mode_w);
        else passed++;
        total++;
        if (chg_w !== 1'b0) $display("FAIL reset_chg: mode_chg=%b, required 0", chg_w);
        else passed++;
        exp_w = 0;
        push_next_w();
        rst = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (k < 6) begin
                if (mode_w !== 3'd0) $display("FAIL reset_early_step: edge %0d mode=%0d, required 0", k, mode_w);
                else passed++;
            end else begin
                if (mode_w !== 3'd1) $display("FAIL reset_held_step: edge %0d mode=%0d, required 1", k, mode_w);
                else passed++;
            end
        end
        kn = 1'b0;
        step(12);
        total++;
        if (q_w.size() != 0) $display("FAIL reset_drain: %0d pending, required 0", q_w.size());
        else passed++;
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 4; i++) begin
            kn = (i % 2 == 0);
            step(1);
        end
        total++;
        if (mode_w !== 3'(exp_w)) $display("FAIL bounce_toggle: mode=%0d, required %0d", mode_w, exp_w);
        else passed++;
        push_next_w();
        kn = 1'b1;
        step(10);
        kn = 1'b0;
        step(12);
        total++;
        if (mode_w !== 3'(exp_w)) $display("FAIL bounce_held: mode=%0d, required %0d", mode_w, exp_w);
        else passed++;
        kn = 1'b1;
        step(3);
        kn = 1'b0;
        step(12);
        total++;
        if (mode_w !== 3'(exp_w)) $display("FAIL bounce_glitch: mode=%0d, required %0d", mode_w, exp_w);
        else passed++;
        total++;
        if (q_w.size() != 0) $display("FAIL bounce_drain: %0d pending, required 0", q_w.size());
        else passed++;
    endtask

    task automatic test_wrap();
        reset_w();
        for (int i = 0; i < 5; i++) begin
            push_next_w();
            press_key(0);
        end
        total++;
        if (mode_w !== 3'd0) $display("FAIL wrap_up: mode=%0d, required 0", mode_w);
        else passed++;
        push_prev_w();
        press_key(1);
        total++;
        if (mode_w !== 3'd4) $display("FAIL wrap_down: mode=%0d, required 4", mode_w);
        else passed++;
        push_prev_w();
        press_key(1);
        total++;
        if (q_w.size() != 0) $display("FAIL wrap_drain: %0d pending, required 0", q_w.size());
        else passed++;
    endtask

    task automatic test_saturate();
        exp_s = 0;
        press_key(3);
        total++;
        if (mode_s !== 3'd0) $display("FAIL sat_low: mode=%0d, required 0", mode_s);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            exp_s = exp_s + 1;
            q_s.push_back({1'b0, 3'(exp_s)});
            press_key(2);
        end
        press_key(2);
        total++;
        if (mode_s !== 3'd4) $display("FAIL sat_high: mode=%0d, required 4", mode_s);
        else passed++;
        ae2 = 1'b1;
        step(20);
        ae2 = 1'b0;
        total++;
        if (mode_s !== 3'd4) $display("FAIL sat_auto: mode=%0d, required 4", mode_s);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            exp_s = exp_s - 1;
            q_s.push_back({1'b0, 3'(exp_s)});
            press_key(3);
        end
        press_key(3);
        total++;
        if (mode_s !== 3'd0) $display("FAIL sat_low_again: mode=%0d, required 0", mode_s);
        else passed++;
        total++;
        if (q_s.size() != 0) $display("FAIL sat_drain: %0d pending, required 0", q_s.size());
        else passed++;
    endtask

    task automatic test_simultaneous();
        reset_w();
        kn = 1'b1;
        kp = 1'b1;
        step(10);
        kn = 1'b0;
        kp = 1'b0;
        step(10);
        total++;
        if (mode_w !== 3'd0) $display("FAIL simul_keys: mode=%0d, required 0", mode_w);
        else passed++;
        push_next_w();
        press_key(0);
        push_next_w();
        press_key(0);
        // Auto tick and PREV press land on the same edge, 8 edges from enable.
        ae = 1'b1;
        step(1);
        kp = 1'b1;
        push_prev_w();
        for (int k = 2; k <= 16; k++) begin
            step(1);
            if (k == 7) begin
                total++;
                if (mode_w !== 3'd2) $display("FAIL simul_before: mode=%0d, required 2", mode_w);
                else passed++;
            end
            if (k == 8) begin
                total++;
                if (mode_w !== 3'd1 || chg_w !== 1'b1)
                    $display("FAIL simul_prev_wins: mode=%0d chg=%b, required mode=1 chg=1", mode_w, chg_w);
                else passed++;
                push_next_w();
            end
            if (k == 10) kp = 1'b0;
            if (k == 15) begin
                total++;
                if (mode_w !== 3'd1) $display("FAIL simul_dwell: mode=%0d, required 1", mode_w);
                else passed++;
            end
            if (k == 16) begin
                total++;
                if (mode_w !== 3'd2) $display("FAIL simul_next_tick: mode=%0d, required 2", mode_w);
                else passed++;
            end
        end
        ae = 1'b0;
        step(12);
        total++;
        if (q_w.size() != 0) $display("FAIL simul_drain: %0d pending, required 0", q_w.size());
        else passed++;
    endtask

    task automatic test_auto();
        reset_w();
        ae = 1'b1;
        for (int i = 0; i < 5; i++) push_next_w();
        for (int k = 1; k <= 40; k++) begin
            step(1);
            total++;
            if (chg_w !== (k % AC == 0))
                $display("FAIL auto_period: cycle %0d chg=%b, required %b", k, chg_w, (k % AC == 0));
            else passed++;
        end
        step(3);
        ae = 1'b0;
        step(1);
        ae = 1'b1;
        push_next_w();
        for (int k = 1; k <= AC; k++) begin
            step(1);
            total++;
            if (chg_w !== (k == AC))
                $display("FAIL auto_reenable: cycle %0d chg=%b, required %b", k, chg_w, (k == AC));
            else passed++;
        end
        step(3);
        rst = 1'b1;
        step(1);
        total++;
        if (mode_w !== 3'd0 || chg_w !== 1'b0)
            $display("FAIL auto_reset: mode=%0d chg=%b, required mode=0 chg=0", mode_w, chg_w);
        else passed++;
        rst   = 1'b0;
        exp_w = 0;
        push_next_w();
        for (int k = 1; k <= AC; k++) begin
            step(1);
            total++;
            if (chg_w !== (k == AC))
                $display("FAIL auto_after_reset: cycle %0d chg=%b, required %b", k, chg_w, (k == AC));
            else passed++;
        end
        ae = 1'b0;
        step(5);
        total++;
        if (q_w.size() != 0) $display("FAIL auto_drain: %0d pending, required 0", q_w.size());
        else passed++;
    endtask

    initial begin
        rst  = 1'b1;
        kn   = 1'b0;
        kp   = 1'b0;
        ae   = 1'b0;
        rst2 = 1'b1;
        kn2  = 1'b1;
        kp2  = 1'b1;
        ae2  = 1'b0;
        fork
            mon_w();
            mon_s();
        join_none
        step(3);
        rst2 = 1'b0;
        test_reset();
        test_bounce();
        test_wrap();
        test_saturate();
        test_simultaneous();
        test_auto();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
